cv32e40px_fp_noncomp_resp: RTL and testbench
============================================

CV32E40PX_FP_NONCOMP_RESP -- requirements
Module: cv32e40px_fp_noncomp_resp

Interface
REQ-001 SHALL have parameter LATENCY, default 1, legal range 1..3: cycles from grant to earliest rvalid.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush_i  in  1  discard all in-flight and buffered results.
- apu_req_i  in  1  request valid.
- apu_gnt_o  out  1  request accepted this cycle.
- apu_op_i  in  4  operation_e code.
- apu_rm_i  in  3  sub-operation select.
- apu_a_i, apu_b_i  in  32  FP32 operands.
- apu_rvalid_o  out  1  result valid.
- apu_rready_i  in  1  result consumed.
- apu_result_o  out  32  result.
- apu_flags_o  out  5  NV,DZ,OF,UF,NX; bit 4 is NV.

Function
REQ-003 SHALL assert apu_gnt_o = apu_req_i & ~flush_i & (outstanding < 2 | pop), where pop = apu_rvalid_o & apu_rready_i.
REQ-004 SHALL count outstanding as pipe entries plus FIFO entries, range 0..2; +1 on grant, -1 on pop, unchanged on both.
REQ-005 SHALL carry each granted request through a non-stalling LATENCY-stage valid/data shift register into a 2-entry FIFO; FIFO head drives the apu_result_o, apu_flags_o and apu_rvalid_o outputs.
REQ-006 SHALL assert apu_rvalid_o in cycle N+LATENCY for a grant in cycle N when the FIFO is empty; results SHALL return in grant order.
REQ-007 SHALL hold the result and flags stable while apu_rvalid_o=1 and apu_rready_i=0.
REQ-008 SHALL implement SGNJ: rm 000 = sign(b); rm 001 = ~sign(b); rm 010 = sign(a)^sign(b); magnitude from a; flags 0.
REQ-009 SHALL implement MINMAX: rm 000 = min, rm 001 = max.
- -0 < +0.
- Exactly one NaN returns the other operand.
- Two NaNs return 0x7FC00000.
- Any sNaN sets NV.
REQ-010 SHALL implement CMP: rm 010 = FEQ, rm 001 = FLT, rm 000 = FLE; result 0 or 1 zero-extended; any NaN gives 0.
- FLE/FLT: NV on any NaN.
- FEQ: NV on sNaN only.
REQ-011 SHALL implement CLASSIFY as the RISC-V 10-bit one-hot class mask of apu_a_i, zero-extended; flags 0.
REQ-012 SHALL return result 0 with flags 5'b10000 for any other op code or undefined rm value; the request is still granted.
REQ-013 SHALL, on flush_i, clear pipe valids, FIFO and outstanding next cycle; apu_rvalid_o=0 the following cycle; a simultaneous request is not granted.

Reset
REQ-014 SHALL, on rst, clear pipe valids, FIFO pointers and the outstanding count, including mid-operation, with all results lost.
REQ-015 SHALL drive apu_gnt_o=0, apu_rvalid_o=0, apu_result_o=0 and apu_flags_o=0 from the first cycle after rst until a new grant.

Configuration
REQ-016 SHALL implement CLASSIFY per REQ-011 only when macro CV32E40PX_FP_CLASSIFY_EN is defined.
REQ-017 SHALL treat CLASSIFY as illegal per REQ-012 when CV32E40PX_FP_CLASSIFY_EN is undefined, with no classify logic synthesised.

Structure
REQ-018 SHALL take operation_e from the shared FPU package.
REQ-019 SHALL add these to the shared FPU package:
- rm sub-op constants: SGNJ, MINMAX, CMP.
- Canonical NaN 0x7FC00000.
- Classify bit indices 0..9.
- Status-flag struct: NV, DZ, OF, UF, NX.
REQ-020 SHALL put the combinational compute logic in sub-module cv32e40px_fp_noncomp_core; handshake, pipe and FIFO stay in the top.

Verification
REQ-021 SHALL cover these directed scenarios (LATENCY=1 unless stated):
- SGNJ rm=001, a=0x3F800000, b=0x3F800000 -> result 0xBF800000, flags 0, rvalid one cycle after grant.
- MINMAX rm=000, a=0x80000000, b=0x00000000 -> 0x80000000; a=0x7F800001, b=0x40000000 -> 0x40000000, flags 0x10.
- CMP rm=010, a=0x7FC00000, b=0x7FC00000 -> 0, flags 0; rm=001, same operands -> 0, flags 0x10.
- CLASSIFY a=0xFF800000 -> 0x00000001 with macro defined; -> 0, flags 0x10 without it.
- rready=0, three back-to-back requests -> two granted, third held until the first pop; results in order and stable while stalled.
- LATENCY=3, flush_i two cycles after a grant -> no rvalid, outstanding 0; same for rst mid-operation.

Source files
------------

// File: rtl/cv32e40px_fp_noncomp_resp_pkg.sv
// Shared FPU package: operation codes, sub-op encodings, status flags and response payload
// for the non-computational FP response unit.
package cv32e40px_fp_noncomp_resp_pkg;

    typedef enum logic [3:0] {
        FMADD, FNMSUB, ADD, MUL, DIV, SQRT, SGNJ, MINMAX, CMP, CLASSIFY,
        F2F, F2I, I2F, CPKAB, CPKCD
    } operation_e;

    localparam logic [2:0] RM_SGNJ_NORMAL = 3'b000;
    localparam logic [2:0] RM_SGNJ_NEG    = 3'b001;
    localparam logic [2:0] RM_SGNJ_XOR    = 3'b010;

    localparam logic [2:0] RM_MIN = 3'b000;
    localparam logic [2:0] RM_MAX = 3'b001;

    localparam logic [2:0] RM_FLE = 3'b000;
    localparam logic [2:0] RM_FLT = 3'b001;
    localparam logic [2:0] RM_FEQ = 3'b010;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    localparam int unsigned CLS_NEG_INF  = 0;
    localparam int unsigned CLS_NEG_NORM = 1;
    localparam int unsigned CLS_NEG_SUB  = 2;
    localparam int unsigned CLS_NEG_ZERO = 3;
    localparam int unsigned CLS_POS_ZERO = 4;
    localparam int unsigned CLS_POS_SUB  = 5;
    localparam int unsigned CLS_POS_NORM = 6;
    localparam int unsigned CLS_POS_INF  = 7;
    localparam int unsigned CLS_SNAN     = 8;
    localparam int unsigned CLS_QNAN     = 9;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

    localparam status_t FLAGS_NONE = 5'b00000;
    localparam status_t FLAGS_NV   = 5'b10000;

    typedef struct packed {
        logic [31:0] result;
        status_t     flags;
    } resp_t;

endpackage

// File: rtl/cv32e40px_fp_noncomp_core.sv
// Combinational FP32 sign-injection, min/max, compare and classify.
// CLASSIFY is only built when CV32E40PX_FP_CLASSIFY_EN is defined; otherwise it is illegal.
module cv32e40px_fp_noncomp_core
    import cv32e40px_fp_noncomp_resp_pkg::*;
(
    input  logic [3:0]  op_i,
    input  logic [2:0]  rm_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] result_o,
    output status_t     flags_o
);

    logic a_nan, b_nan, a_snan, b_snan;
    logic both_zero, raw_lt, cmp_lt, cmp_eq;

    assign a_nan  = (a_i[30:23] == 8'hFF) && (a_i[22:0] != '0);
    assign b_nan  = (b_i[30:23] == 8'hFF) && (b_i[22:0] != '0);
    assign a_snan = a_nan && !a_i[22];
    assign b_snan = b_nan && !b_i[22];

    assign both_zero = (a_i[30:0] == '0) && (b_i[30:0] == '0);

    // Sign-magnitude ordering that places -0 below +0; compares treat the zeros as equal.
    always_comb begin
        if (a_i[31] != b_i[31]) begin
            raw_lt = a_i[31];
        end else if (!a_i[31]) begin
            raw_lt = a_i[30:0] < b_i[30:0];
        end else begin
            raw_lt = a_i[30:0] > b_i[30:0];
        end
    end

    assign cmp_lt = raw_lt && !both_zero;
    assign cmp_eq = (a_i == b_i) || both_zero;

`ifdef CV32E40PX_FP_CLASSIFY_EN
    logic [9:0] cls_mask;
    logic       exp_ones, exp_zero, man_zero;

    assign exp_ones = a_i[30:23] == 8'hFF;
    assign exp_zero = a_i[30:23] == 8'h00;
    assign man_zero = a_i[22:0] == '0;

    always_comb begin
        cls_mask               = '0;
        cls_mask[CLS_NEG_INF]  = a_i[31] && exp_ones && man_zero;
        cls_mask[CLS_NEG_NORM] = a_i[31] && !exp_ones && !exp_zero;
        cls_mask[CLS_NEG_SUB]  = a_i[31] && exp_zero && !man_zero;
        cls_mask[CLS_NEG_ZERO] = a_i[31] && exp_zero && man_zero;
        cls_mask[CLS_POS_ZERO] = !a_i[31] && exp_zero && man_zero;
        cls_mask[CLS_POS_SUB]  = !a_i[31] && exp_zero && !man_zero;
        cls_mask[CLS_POS_NORM] = !a_i[31] && !exp_ones && !exp_zero;
        cls_mask[CLS_POS_INF]  = !a_i[31] && exp_ones && man_zero;
        cls_mask[CLS_SNAN]     = a_snan;
        cls_mask[CLS_QNAN]     = a_nan && a_i[22];
    end
`endif

    always_comb begin
        result_o = '0;
        flags_o  = FLAGS_NONE;
        case (operation_e'(op_i))
            SGNJ: begin
                case (rm_i)
                    RM_SGNJ_NORMAL: result_o = {b_i[31], a_i[30:0]};
                    RM_SGNJ_NEG:    result_o = {~b_i[31], a_i[30:0]};
                    RM_SGNJ_XOR:    result_o = {a_i[31] ^ b_i[31], a_i[30:0]};
                    default:        flags_o  = FLAGS_NV;
                endcase
            end
            MINMAX: begin
                if (rm_i == RM_MIN || rm_i == RM_MAX) begin
                    flags_o.nv = a_snan | b_snan;
                    if (a_nan && b_nan) begin
                        result_o = CANON_NAN;
                    end else if (a_nan) begin
                        result_o = b_i;
                    end else if (b_nan) begin
                        result_o = a_i;
                    end else if (rm_i == RM_MIN) begin
                        result_o = raw_lt ? a_i : b_i;
                    end else begin
                        result_o = raw_lt ? b_i : a_i;
                    end
                end else begin
                    flags_o = FLAGS_NV;
                end
            end
            CMP: begin
                case (rm_i)
                    RM_FLE: begin
                        flags_o.nv  = a_nan | b_nan;
                        result_o[0] = !(a_nan || b_nan) && (cmp_lt || cmp_eq);
                    end
                    RM_FLT: begin
                        flags_o.nv  = a_nan | b_nan;
                        result_o[0] = !(a_nan || b_nan) && cmp_lt;
                    end
                    RM_FEQ: begin
                        flags_o.nv  = a_snan | b_snan;
                        result_o[0] = !(a_nan || b_nan) && cmp_eq;
                    end
                    default: flags_o = FLAGS_NV;
                endcase
            end
`ifdef CV32E40PX_FP_CLASSIFY_EN
            CLASSIFY: result_o = {22'd0, cls_mask};
`endif
            default: flags_o = FLAGS_NV;
        endcase
    end

endmodule

// File: rtl/cv32e40px_fp_noncomp_resp.sv
// Non-computational FP response unit: grant/outstanding handshake, LATENCY-deep result pipe
// and 2-entry output FIFO. Optional CLASSIFY via macro CV32E40PX_FP_CLASSIFY_EN.
module cv32e40px_fp_noncomp_resp
    import cv32e40px_fp_noncomp_resp_pkg::*;
#(
    parameter int unsigned LATENCY = 1  // legal range 1..3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic        apu_req_i,
    output logic        apu_gnt_o,
    input  logic [3:0]  apu_op_i,
    input  logic [2:0]  apu_rm_i,
    input  logic [31:0] apu_a_i,
    input  logic [31:0] apu_b_i,
    output logic        apu_rvalid_o,
    input  logic        apu_rready_i,
    output logic [31:0] apu_result_o,
    output logic [4:0]  apu_flags_o
);

    resp_t       core_resp;
    logic        pop;
    logic        push;
    resp_t       push_data;
    logic [1:0]  outst_q;
    logic [1:0]  fifo_cnt_q;
    logic        wptr_q, rptr_q;
    resp_t       fifo_mem_q [2];

    cv32e40px_fp_noncomp_core u_core (
        .op_i     (apu_op_i),
        .rm_i     (apu_rm_i),
        .a_i      (apu_a_i),
        .b_i      (apu_b_i),
        .result_o (core_resp.result),
        .flags_o  (core_resp.flags)
    );

    assign pop       = apu_rvalid_o & apu_rready_i;
    assign apu_gnt_o = apu_req_i & ~flush_i & ~rst & ((outst_q < 2'd2) | pop);

    // The FIFO write is the last of the LATENCY stages, so LATENCY-1 pipe registers precede it.
    if (LATENCY == 1) begin : g_direct
        assign push      = apu_gnt_o;
        assign push_data = core_resp;
    end else begin : g_pipe
        logic [LATENCY-2:0] vld_q;
        resp_t              data_q [LATENCY-1];

        always_ff @(posedge clk) begin
            if (rst || flush_i) begin
                vld_q <= '0;
            end else begin
                vld_q[0] <= apu_gnt_o;
                for (int s = 1; s < int'(LATENCY) - 1; s++) begin
                    vld_q[s] <= vld_q[s-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            data_q[0] <= core_resp;
            for (int s = 1; s < int'(LATENCY) - 1; s++) begin
                data_q[s] <= data_q[s-1];
            end
        end

        assign push      = vld_q[LATENCY-2];
        assign push_data = data_q[LATENCY-2];
    end

    // Outstanding never exceeds 2, so the FIFO cannot overflow.
    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            fifo_cnt_q <= 2'd0;
            outst_q    <= 2'd0;
        end else begin
            if (push) begin
                wptr_q <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            fifo_cnt_q <= fifo_cnt_q + 2'(push) - 2'(pop);
            outst_q    <= outst_q + 2'(apu_gnt_o) - 2'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wptr_q] <= push_data;
        end
    end

    assign apu_rvalid_o = fifo_cnt_q != 2'd0;
    assign apu_result_o = apu_rvalid_o ? fifo_mem_q[rptr_q].result : 32'd0;
    assign apu_flags_o  = apu_rvalid_o ? fifo_mem_q[rptr_q].flags : 5'd0;

endmodule

// File: tb/tb_cv32e40px_fp_noncomp_resp.sv
// Scoreboard bench for cv32e40px_fp_noncomp_resp: a LATENCY=1 and a LATENCY=3 instance.
module tb_cv32e40px_fp_noncomp_resp;
    import cv32e40px_fp_noncomp_resp_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush1, req1, gnt1, rvalid1, rready1;
    logic [3:0]  op1;
    logic [2:0]  rm1;
    logic [31:0] a1, b1, res1;
    logic [4:0]  flags1;
    logic        flush3, req3, gnt3, rvalid3, rready3;
    logic [3:0]  op3;
    logic [2:0]  rm3;
    logic [31:0] a3, b3, res3;
    logic [4:0]  flags3;

    int checks = 0;
    int failures = 0;
    logic [36:0] q1[$];
    logic [36:0] q3[$];
    bit rnd_run;

    always #5 clk = ~clk;

    cv32e40px_fp_noncomp_resp #(.LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .flush_i(flush1), .apu_req_i(req1), .apu_gnt_o(gnt1),
        .apu_op_i(op1), .apu_rm_i(rm1), .apu_a_i(a1), .apu_b_i(b1), .apu_rvalid_o(rvalid1),
        .apu_rready_i(rready1), .apu_result_o(res1), .apu_flags_o(flags1)
    );

    cv32e40px_fp_noncomp_resp #(.LATENCY(3)) u_dut3 (
        .clk(clk), .rst(rst), .flush_i(flush3), .apu_req_i(req3), .apu_gnt_o(gnt3),
        .apu_op_i(op3), .apu_rm_i(rm3), .apu_a_i(a3), .apu_b_i(b3), .apu_rvalid_o(rvalid3),
        .apu_rready_i(rready3), .apu_result_o(res3), .apu_flags_o(flags3)
    );

    // Reference model: {result, flags}
    function automatic logic [36:0] model(input logic [3:0] op, input logic [2:0] rm,
                                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic [4:0]  f;
        logic        na, nb, sa, sb, a_less;
        longint      ka, kb;
        int          idx;
        na = (a[30:23] == 8'hFF) && (a[22:0] != 0);
        nb = (b[30:23] == 8'hFF) && (b[22:0] != 0);
        sa = na && (a[22] == 1'b0);
        sb = nb && (b[22] == 1'b0);
        ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
        kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
        r = 0;
        f = 5'b10000;
        if (op == SGNJ && rm <= 3'd2) begin
            f = 0;
            if (rm == 3'd0) r = {b[31], a[30:0]};
            else if (rm == 3'd1) r = {!b[31], a[30:0]};
            else r = {a[31] ^ b[31], a[30:0]};
        end else if (op == MINMAX && rm <= 3'd1) begin
            f = {sa | sb, 4'b0};
            a_less = (ka < kb) || (ka == kb && a[31] && !b[31]);
            if (na && nb) r = 32'h7FC00000;
            else if (na) r = b;
            else if (nb) r = a;
            else if (rm == 3'd0) r = a_less ? a : b;
            else r = a_less ? b : a;
        end else if (op == CMP && rm <= 3'd2) begin
            if (rm == 3'd2) f = {sa | sb, 4'b0};
            else f = {na | nb, 4'b0};
            if (na || nb) r = 0;
            else if (rm == 3'd0) r = (ka <= kb) ? 1 : 0;
            else if (rm == 3'd1) r = (ka < kb) ? 1 : 0;
            else r = (ka == kb) ? 1 : 0;
`ifdef CV32E40PX_FP_CLASSIFY_EN
        end else if (op == CLASSIFY) begin
            f = 0;
            if (a[30:23] == 8'hFF) idx = (a[22:0] == 0) ? (a[31] ? 0 : 7) : (a[22] ? 9 : 8);
            else if (a[30:23] == 0) idx = (a[22:0] == 0) ? (a[31] ? 3 : 4) : (a[31] ? 2 : 5);
            else idx = a[31] ? 1 : 6;
            r = 32'd1 << idx;
`endif
        end
        return {r, f};
    endfunction

    // Monitor for the LATENCY=1 instance: order/value scoreboard plus hold-while-stalled check.
    initial begin
        logic        stall1 = 1'b0;
        logic [36:0] held1 = '0;
        logic [36:0] exp1;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall1 = 1'b0;
            end else begin
                if (stall1) begin
                    checks++;
                    if (rvalid1 !== 1'b1 || {res1, flags1} !== held1) begin
                        failures++;
                        $display("FAIL stall_hold1 got rvalid=%b %h/%h want rvalid=1 %h/%h",
                                 rvalid1, res1, flags1, held1[36:5], held1[4:0]);
                    end
                end
                if (rvalid1 && rready1) begin
                    checks++;
                    if (q1.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_rvalid1 got %h/%h want no result", res1, flags1);
                    end else begin
                        exp1 = q1.pop_front();
                        if ({res1, flags1} !== exp1) begin
                            failures++;
                            $display("FAIL result1 got %h/%h want %h/%h",
                                     res1, flags1, exp1[36:5], exp1[4:0]);
                        end
                    end
                end
                stall1 = rvalid1 && !rready1;
                held1  = {res1, flags1};
            end
        end
    end

    initial begin
        logic [36:0] exp3;
        forever begin
            @(negedge clk);
            if (!rst && rvalid3 && rready3) begin
                checks++;
                if (q3.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_rvalid3 got %h/%h want no result", res3, flags3);
                end else begin
                    exp3 = q3.pop_front();
                    if ({res3, flags3} !== exp3) begin
                        failures++;
                        $display("FAIL result3 got %h/%h want %h/%h",
                                 res3, flags3, exp3[36:5], exp3[4:0]);
                    end
                end
            end
        end
    end

    task automatic issue1(input logic [3:0] op, input logic [2:0] rm, input logic [31:0] a,
                          input logic [31:0] b, input logic [36:0] exp);
        int n = 0;
        bit done = 0;
        op1 = op; rm1 = rm; a1 = a; b1 = b; req1 = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (gnt1) begin
                q1.push_back(exp);
                done = 1;
            end else begin
                n++;
                if (n > 50) begin
                    checks++; failures++;
                    $display("FAIL issue1_timeout got no grant want grant within 50 cycles");
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
        req1 = 1'b0;
    endtask

    task automatic drain1();
        int n = 0;
        rready1 = 1'b1;
        while (q1.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (q1.size() != 0) begin
            failures++;
            $display("FAIL drain1 got %0d pending want 0", q1.size());
        end
    endtask

    task automatic drain3();
        int n = 0;
        rready3 = 1'b1;
        while (q3.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (q3.size() != 0) begin
            failures++;
            $display("FAIL drain3 got %0d pending want 0", q3.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({gnt1, rvalid1, res1, flags1, gnt3, rvalid3, res3, flags3} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b%b rv=%b%b res=%h/%h fl=%h/%h want all 0",
                     gnt1, gnt3, rvalid1, rvalid3, res1, res3, flags1, flags3);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sgnj_latency();
        rready1 = 1'b1;
        op1 = SGNJ; rm1 = RM_SGNJ_NEG; a1 = 32'h3F800000; b1 = 32'h3F800000; req1 = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt1 !== 1'b1 || rvalid1 !== 1'b0) begin
            failures++;
            $display("FAIL sgnj_grant got gnt=%b rvalid=%b want gnt=1 rvalid=0", gnt1, rvalid1);
        end else begin
            q1.push_back({32'hBF800000, 5'b00000});
        end
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        checks++;
        if (rvalid1 !== 1'b1) begin
            failures++;
            $display("FAIL sgnj_latency got rvalid=%b want 1 one cycle after grant", rvalid1);
        end
        @(posedge clk); #1;
        drain1();
    endtask

    task automatic test_directed();
        rready1 = 1'b1;
        issue1(MINMAX, RM_MIN, 32'h80000000, 32'h00000000, {32'h80000000, 5'b00000});
        issue1(MINMAX, RM_MIN, 32'h7F800001, 32'h40000000, {32'h40000000, 5'b10000});
        issue1(CMP, RM_FEQ, 32'h7FC00000, 32'h7FC00000, {32'h00000000, 5'b00000});
        issue1(CMP, RM_FLT, 32'h7FC00000, 32'h7FC00000, {32'h00000000, 5'b10000});
`ifdef CV32E40PX_FP_CLASSIFY_EN
        issue1(CLASSIFY, 3'd0, 32'hFF800000, 32'h0, {32'h00000001, 5'b00000});
`else
        issue1(CLASSIFY, 3'd0, 32'hFF800000, 32'h0, {32'h00000000, 5'b10000});
`endif
        issue1(ADD, 3'd0, 32'h3F800000, 32'h3F800000, {32'h00000000, 5'b10000});
        issue1(SGNJ, 3'd5, 32'h3F800000, 32'h3F800000, {32'h00000000, 5'b10000});
        drain1();
    endtask

    task automatic test_back_to_back();
        rready1 = 1'b0;
        req1 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            op1 = (i == 0) ? SGNJ : (i == 1) ? MINMAX : CMP;
            rm1 = (i == 0) ? RM_SGNJ_XOR : (i == 1) ? RM_MAX : RM_FLE;
            a1  = (i == 0) ? 32'hC0000000 : (i == 1) ? 32'h00000000 : 32'h3F800000;
            b1  = (i == 0) ? 32'hBF800000 : (i == 1) ? 32'h80000000 : 32'h40000000;
            if (i == 5) rready1 = 1'b1;
            @(negedge clk);
            checks++;
            if (gnt1 !== ((i < 2 || i == 5) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL b2b_grant_%0d got %b want %b", i, gnt1, (i < 2 || i == 5));
            end else if (gnt1) begin
                q1.push_back(model(op1, rm1, a1, b1));
            end
            @(posedge clk); #1;
        end
        req1 = 1'b0;
        drain1();
    endtask

    task automatic test_random();
        logic [31:0] pool [12] = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                                   32'h7F800000, 32'hFF800000, 32'h7FC00000, 32'h7F800001,
                                   32'h00000001, 32'h80400000, 32'h40000000, 32'hC0000000};
        logic [3:0]  ops [5] = '{SGNJ, MINMAX, CMP, CLASSIFY, ADD};
        logic [3:0]  op;
        logic [2:0]  rm;
        logic [31:0] a, b;
        rnd_run = 1'b1;
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    op = ops[$urandom_range(0, 4)];
                    rm = 3'($urandom_range(0, ($urandom_range(0, 3) == 0) ? 7 : 2));
                    a  = pool[$urandom_range(0, 11)];
                    b  = pool[$urandom_range(0, 11)];
                    issue1(op, rm, a, b, model(op, rm, a, b));
                end
                rnd_run = 1'b0;
            end
            begin
                while (rnd_run) begin
                    @(posedge clk); #1;
                    rready1 = 1'($urandom_range(0, 1));
                end
            end
        join
        drain1();
    endtask

    task automatic test_cnt_cleared3();
        rready3 = 1'b0;
        op3 = CMP; rm3 = RM_FEQ; a3 = 32'h3F800000; b3 = 32'h3F800000; req3 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (gnt3 !== ((i < 2) ? 1'b1 : 1'b0)) begin
                failures++;
                $display("FAIL outstanding3_grant_%0d got %b want %b", i, gnt3, i < 2);
            end else if (gnt3) begin
                q3.push_back({32'h00000001, 5'b00000});
            end
            @(posedge clk); #1;
        end
        req3 = 1'b0;
        drain3();
    endtask

    task automatic start_l3_op();
        rready3 = 1'b1;
        op3 = SGNJ; rm3 = RM_SGNJ_NORMAL; a3 = 32'h3F800000; b3 = 32'h80000000; req3 = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt3 !== 1'b1) begin
            failures++;
            $display("FAIL l3_grant got %b want 1", gnt3);
        end
        @(posedge clk); #1;
        req3 = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_flush_l3();
        start_l3_op();
        flush3 = 1'b1;
        req3 = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt3 !== 1'b0) begin
            failures++;
            $display("FAIL flush_blocks_req got gnt=%b want 0", gnt3);
        end
        @(posedge clk); #1;
        flush3 = 1'b0;
        req3 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (rvalid3 !== 1'b0) begin
                failures++;
                $display("FAIL flush_no_rvalid_%0d got %b want 0", i, rvalid3);
            end
            @(posedge clk); #1;
        end
        test_cnt_cleared3();
    endtask

    task automatic test_reset_mid_l3();
        start_l3_op();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if ({gnt3, rvalid3, res3, flags3} !== '0) begin
                failures++;
                $display("FAIL reset_mid_%0d got gnt=%b rvalid=%b %h/%h want all 0",
                         i, gnt3, rvalid3, res3, flags3);
            end
            @(posedge clk); #1;
        end
        test_cnt_cleared3();
    endtask

    initial begin
        rst = 1'b1;
        {flush1, req1, rready1, op1, rm1, a1, b1} = '0;
        {flush3, req3, rready3, op3, rm3, a3, b3} = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        test_reset();
        test_sgnj_latency();
        test_directed();
        test_back_to_back();
        test_random();
        test_flush_l3();
        test_reset_mid_l3();
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
